// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the vector pipeline.
// Performs scalar (32-bit) and vector (LANES x 32-bit) loads and stores over
// a single 32-bit synchronous data-memory port. Vector accesses are split into
// one beat per lane by a small FSM. Upstream is stalled until the access ends.
//
// Optional build macro MEM_STAGE_PERF_EN: adds output stall_cnt, a saturating
// count of cycles with stall_M=1. Without it the port and counter are absent.
//
// LANES must be at least 2. The lane buffer holds lanes 0..LANES-2. The last
// lane is taken straight from mem_q on the final vector-load cycle.
module mem_stage #(
  parameter int ADDR_W = 10,
  parameter int LANES  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_M,
  input  logic                  regw_M,
  input  logic                  regmem_M,
  input  logic                  memwr_M,
  input  logic                  vec_M,
  input  logic [3:0]            regScr_M,
  input  logic [31:0]           ALUrslt_M,
  input  logic [31:0]           wdata_M,
  input  logic [32*LANES-1:0]   regVrslt_M,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [31:0]           mem_data,
  output logic                  mem_wren,
  input  logic [31:0]           mem_q,
  output logic                  stall_M,
  output logic                  regw_MW,
  output logic                  regmem_MW,
  output logic [3:0]            regScr_MW,
  output logic [31:0]           ALUrslt_MW,
  output logic [32*LANES-1:0]   regVrslt_MW
`ifdef MEM_STAGE_PERF_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);

  localparam int BEAT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int BUF_W  = 32 * (LANES - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LANES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SLD  = 2'd1,
    VLD  = 2'd2,
    VST  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [BUF_W-1:0]  lane_buf_q, lane_buf_d;

  logic [ADDR_W-1:0]   base_s;
  logic                stall_s;
  logic                regw_s;
  logic                regmem_s;
  logic                wren_s;
  logic [31:0]         alu_s;
  logic [32*LANES-1:0] vr_s;

  // Select lane idx of a vector; unmatched lanes contribute zero.
  function automatic logic [31:0] lane_sel(input logic [32*LANES-1:0] v,
                                           input logic [BEAT_W-1:0]   idx);
    logic [31:0] r;
    r = 32'd0;
    for (int k = 0; k < LANES; k++) begin
      r = r | (v[32*k +: 32] & {32{idx == BEAT_W'(k)}});
    end
    return r;
  endfunction

  // Next beat, wrapping from the last lane back to zero.
  function automatic logic [BEAT_W-1:0] beat_next(input logic [BEAT_W-1:0] b);
    return (b == LAST_BEAT) ? BEAT_W'(0) : (b + BEAT_W'(1));
  endfunction

  assign base_s = ALUrslt_M[ADDR_W-1:0];

  // FSM next state, memory port drive and raw (pre-reset-gating) outputs.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    lane_buf_d = lane_buf_q;
    mem_addr   = base_s + ADDR_W'(beat_q);
    mem_data   = wdata_M;
    wren_s     = 1'b0;
    stall_s    = 1'b0;
    regw_s     = 1'b0;
    regmem_s   = 1'b0;
    alu_s      = ALUrslt_M;
    vr_s       = regVrslt_M;

    case (state_q)
      IDLE: begin
        beat_d = BEAT_W'(0);
        if (!valid_M) begin
          // Bubble: no access, nothing written back.
          regw_s   = 1'b0;
          regmem_s = 1'b0;
        end else if (memwr_M) begin
          // Stores win over loads and never write the register file.
          wren_s   = 1'b1;
          regw_s   = 1'b0;
          regmem_s = 1'b0;
          if (vec_M) begin
            mem_data = lane_sel(regVrslt_M, beat_q);
            stall_s  = 1'b1;
            beat_d   = BEAT_W'(1);
            state_d  = VST;
          end else begin
            mem_data = wdata_M;
          end
        end else if (regmem_M) begin
          stall_s = 1'b1;
          if (vec_M) begin
            beat_d  = BEAT_W'(1);
            state_d = VLD;
          end else begin
            state_d = SLD;
          end
        end else begin
          // Non-memory op passes straight through.
          regw_s   = regw_M;
          regmem_s = regmem_M;
        end
      end

      SLD: begin
        alu_s    = mem_q;
        regw_s   = regw_M;
        regmem_s = 1'b1;
        state_d  = IDLE;
      end

      VST: begin
        wren_s   = 1'b1;
        mem_data = lane_sel(regVrslt_M, beat_q);
        if (beat_q == LAST_BEAT) begin
          // Last lane: release upstream in this same cycle.
          beat_d  = BEAT_W'(0);
          state_d = IDLE;
        end else begin
          beat_d  = beat_q + BEAT_W'(1);
          stall_s = 1'b1;
        end
      end

      VLD: begin
        // Data read for the previous beat lands in lane beat-1.
        for (int k = 0; k < LANES - 1; k++) begin
          lane_buf_d[32*k +: 32] = (beat_q == BEAT_W'(k + 1)) ? mem_q
                                                               : lane_buf_q[32*k +: 32];
        end
        if (beat_q == BEAT_W'(0)) begin
          // Beat counter wrapped: all reads issued, last lane is on mem_q.
          vr_s     = {mem_q, lane_buf_q};
          regw_s   = regw_M;
          regmem_s = 1'b1;
          state_d  = IDLE;
        end else begin
          beat_d  = beat_next(beat_q);
          stall_s = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        beat_d  = BEAT_W'(0);
      end
    endcase
  end

  // Control outputs are forced quiet while reset is asserted; data follows inputs.
  always_comb begin
    stall_M     = rst & stall_s;
    mem_wren    = rst & wren_s;
    regw_MW     = rst & ~stall_s & regw_s;
    regmem_MW   = rst & ~stall_s & regmem_s;
    regScr_MW   = regScr_M;
    ALUrslt_MW  = alu_s;
    regVrslt_MW = vr_s;
  end

  // FSM state, beat counter and lane buffer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      beat_q     <= BEAT_W'(0);
      lane_buf_q <= BUF_W'(0);
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      lane_buf_q <= lane_buf_d;
    end
  end

`ifdef MEM_STAGE_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of stalled cycles.
  always_comb begin
    if (stall_M && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: scoreboard of expected write-back values
// and expected memory writes, filled by the stimulus task from an op-level
// reference model (word array), popped by independent monitors.
module tb_mem_stage;
  localparam int ADDR_W = 10;
  localparam int LANES  = 4;
  localparam int VW     = 32 * LANES;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              valid_M, regw_M, regmem_M, memwr_M, vec_M;
  logic [3:0]        regScr_M;
  logic [31:0]       ALUrslt_M, wdata_M;
  logic [VW-1:0]     regVrslt_M;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_data;
  logic              mem_wren;
  logic [31:0]       mem_q;
  logic              stall_M, regw_MW, regmem_MW;
  logic [3:0]        regScr_MW;
  logic [31:0]       ALUrslt_MW;
  logic [VW-1:0]     regVrslt_MW;
`ifdef MEM_STAGE_PERF_EN
  logic [31:0]       stall_cnt;
`endif

  mem_stage #(.ADDR_W(ADDR_W), .LANES(LANES)) dut (
    .clk(clk), .rst(rst),
    .valid_M(valid_M), .regw_M(regw_M), .regmem_M(regmem_M), .memwr_M(memwr_M),
    .vec_M(vec_M), .regScr_M(regScr_M), .ALUrslt_M(ALUrslt_M), .wdata_M(wdata_M),
    .regVrslt_M(regVrslt_M), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_wren(mem_wren), .mem_q(mem_q), .stall_M(stall_M), .regw_MW(regw_MW),
    .regmem_MW(regmem_MW), .regScr_MW(regScr_MW), .ALUrslt_MW(ALUrslt_MW),
    .regVrslt_MW(regVrslt_MW)
`ifdef MEM_STAGE_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  // Environment: synchronous data memory, read data one cycle after address.
  bit [31:0] tb_mem [0:DEPTH-1];
  always @(posedge clk) begin
    if (mem_wren) tb_mem[mem_addr] <= mem_data;
    mem_q <= tb_mem[mem_addr];
  end

  // Reference model contents, updated at op level when a store is issued.
  bit [31:0] ref_mem [0:DEPTH-1];

  typedef struct packed {
    logic          regw;
    logic          regmem;
    logic [3:0]    scr;
    logic [31:0]   alu;
    logic [VW-1:0] vr;
  } exp_t;
  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
  } wr_t;

  exp_t exp_q[$];
  wr_t  wr_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Write-back monitor: a completed instruction is visible when valid and not stalled.
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst && valid_M && !stall_M) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_unexpected: output with empty scoreboard, ALUrslt_MW %h", ALUrslt_MW);
      end else begin
        mon_e = exp_q.pop_front();
        chk("regw_MW", VW'(regw_MW), VW'(mon_e.regw));
        chk("regmem_MW", VW'(regmem_MW), VW'(mon_e.regmem));
        chk("regScr_MW", VW'(regScr_MW), VW'(mon_e.scr));
        chk("ALUrslt_MW", VW'(ALUrslt_MW), VW'(mon_e.alu));
        chk("regVrslt_MW", regVrslt_MW, mon_e.vr);
      end
    end
  end

  // Memory-write monitor.
  wr_t mon_w;
  always @(negedge clk) begin
    if (rst && mem_wren) begin
      if (wr_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL wr_unexpected: write addr %0d data %h", mem_addr, mem_data);
      end else begin
        mon_w = wr_q.pop_front();
        chk("wr_addr", VW'(mem_addr), VW'(mon_w.a));
        chk("wr_data", VW'(mem_data), VW'(mon_w.d));
      end
    end
  end

  // kind: 0 alu, 1 bubble, 2 scalar store, 3 scalar load, 4 vector store, 5 vector load
  task automatic run_op(input int kind, input logic [31:0] alu, input logic [3:0] scr,
                        input logic rw, input logic [31:0] wd, input logic [VW-1:0] vr);
    exp_t e;
    wr_t  w;
    int   base, exp_stall, stalls;
    bit   done;
    base      = int'(alu[ADDR_W-1:0]);
    exp_stall = 0;
    e.regw = rw; e.regmem = 1'b0; e.scr = scr; e.alu = alu; e.vr = vr;
    case (kind)
      2: begin
        e.regw = 1'b0;
        w.a = ADDR_W'(base); w.d = wd; wr_q.push_back(w);
        ref_mem[base] = wd;
      end
      3: begin
        e.alu = ref_mem[base]; e.regmem = 1'b1; exp_stall = 1;
      end
      4: begin
        e.regw = 1'b0; exp_stall = LANES - 1;
        for (int k = 0; k < LANES; k++) begin
          w.a = ADDR_W'((base + k) % DEPTH); w.d = vr[32*k +: 32];
          wr_q.push_back(w);
          ref_mem[(base + k) % DEPTH] = vr[32*k +: 32];
        end
      end
      5: begin
        e.regmem = 1'b1; exp_stall = LANES;
        for (int k = 0; k < LANES; k++) e.vr[32*k +: 32] = ref_mem[(base + k) % DEPTH];
      end
      default: ;
    endcase
    if (kind != 1) exp_q.push_back(e);

    valid_M    = (kind != 1);
    regw_M     = rw;
    regmem_M   = (kind == 3 || kind == 5) ? 1'b1 : (kind == 1 ? 1'($urandom) : 1'b0);
    memwr_M    = (kind == 2 || kind == 4) ? 1'b1 : (kind == 1 ? 1'($urandom) : 1'b0);
    vec_M      = (kind >= 4) ? 1'b1 : ((kind >= 2) ? 1'b0 : 1'($urandom));
    regScr_M   = scr;
    ALUrslt_M  = alu;
    wdata_M    = wd;
    regVrslt_M = vr;

    stalls = 0;
    done   = 1'b0;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      if ((kind == 5 && n < LANES) || (kind == 3 && n == 0))
        chk("rd_addr", VW'(mem_addr), VW'((base + n) % DEPTH));
      if (kind == 0 || kind == 1 || kind == 3 || kind == 5)
        chk("no_wren", VW'(mem_wren), VW'(0));
      if (stall_M) stalls++;
      else done = 1'b1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL stall_timeout: kind %0d still stalled after 20 cycles", kind);
    end
    if (kind == 1) begin
      chk("bubble_regw", VW'(regw_MW), VW'(0));
      chk("bubble_regmem", VW'(regmem_MW), VW'(0));
    end
    chk("stall_cycles", VW'(stalls), VW'(exp_stall));
    @(posedge clk); #1;
  endtask

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int k = 0; k < LANES; k++) v[32*k +: 32] = $urandom;
    return v;
  endfunction

  logic [VW-1:0] v0;
  logic [31:0]   cnt0;
  int            kind_r;
  logic [31:0]   a_r;

  initial begin
    // Reset with a vector load presented: control outputs must stay quiet.
    rst = 1'b0;
    valid_M = 1'b1; regw_M = 1'b1; regmem_M = 1'b1; memwr_M = 1'b0; vec_M = 1'b1;
    regScr_M = 4'd7; ALUrslt_M = 32'h0000_0040; wdata_M = 32'd0;
    regVrslt_M = 128'hA5A5A5A5_5A5A5A5A_01234567_89ABCDEF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", VW'(stall_M), VW'(0));
    chk("rst_wren", VW'(mem_wren), VW'(0));
    chk("rst_regw", VW'(regw_MW), VW'(0));
    chk("rst_regmem", VW'(regmem_MW), VW'(0));
    chk("rst_vr_pass", regVrslt_MW, 128'hA5A5A5A5_5A5A5A5A_01234567_89ABCDEF);
`ifdef MEM_STAGE_PERF_EN
    chk("rst_stall_cnt", VW'(stall_cnt), VW'(0));
`endif
    @(posedge clk); #1;
    valid_M = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed cases.
    run_op(0, 32'h0000_FFFF, 4'b0011, 1'b1, 32'd0, rand_vec());
    run_op(2, 32'd5, 4'd1, 1'b1, 32'hDEAD_BEEF, rand_vec());
    run_op(3, 32'd5, 4'd2, 1'b1, 32'd0, rand_vec());
    run_op(4, 32'd8, 4'd3, 1'b1, 32'd0, 128'h44444444_33333333_22222222_11111111);
`ifdef MEM_STAGE_PERF_EN
    cnt0 = stall_cnt;
`endif
    run_op(5, 32'd8, 4'd4, 1'b1, 32'd0, rand_vec());
`ifdef MEM_STAGE_PERF_EN
    chk("stall_cnt_vld", VW'(stall_cnt - cnt0), VW'(4));
`endif
    run_op(4, 32'd1022, 4'd5, 1'b0, 32'd0, rand_vec());
    run_op(5, 32'd1022, 4'd6, 1'b1, 32'd0, rand_vec());
    run_op(1, 32'd3, 4'd7, 1'b1, 32'd9, rand_vec());

    // Randomized traffic over a small window plus the wrap region.
    for (int i = 0; i < 300; i++) begin
      kind_r = int'($urandom_range(0, 5));
      a_r = $urandom;
      a_r[ADDR_W-1:0] = ($urandom_range(0, 3) == 0) ? ADDR_W'(1020 + $urandom_range(0, 3))
                                                    : ADDR_W'($urandom_range(0, 31));
      run_op(kind_r, a_r, 4'($urandom), 1'($urandom), $urandom, rand_vec());
    end

    // Reset in the second vector-load beat.
    valid_M = 1'b1; regw_M = 1'b1; regmem_M = 1'b1; memwr_M = 1'b0; vec_M = 1'b1;
    ALUrslt_M = 32'd100; regScr_M = 4'd9;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midrst_stall", VW'(stall_M), VW'(0));
    chk("midrst_wren", VW'(mem_wren), VW'(0));
    chk("midrst_regw", VW'(regw_MW), VW'(0));
    chk("midrst_regmem", VW'(regmem_MW), VW'(0));
`ifdef MEM_STAGE_PERF_EN
    chk("midrst_stall_cnt", VW'(stall_cnt), VW'(0));
`endif
    valid_M = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    v0 = rand_vec();
    run_op(0, 32'h1234_5678, 4'd10, 1'b1, 32'd0, v0);

    // Drain.
    valid_M = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", VW'(exp_q.size()), VW'(0));
    chk("wr_drained", VW'(wr_q.size()), VW'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the vector processor pipeline. It sits between the execute/memory pipe register and `mwpipe`, and drives `mwpipe`'s `_M` inputs. It performs scalar (32-bit) and vector (LANES×32-bit) loads and stores over a single 32-bit synchronous data-memory port. Vector accesses are split into per-lane beats under a small FSM, and upstream is stalled until the access completes.

## Interface
- `ADDR_W`, 10, word-address width of the data memory.
- `LANES`, 4, 32-bit lanes per vector; vector width is 32·LANES (128 by default).

- `clk` in 1: pipeline clock.
- `rst` in 1: reset, asynchronous, active-low.
- `valid_M` in 1: instruction present in M stage.
- `regw_M` in 1: register write enable.
- `regmem_M` in 1: load.
- `memwr_M` in 1: store.
- `vec_M` in 1: access is vector (LANES words).
- `regScr_M` in 4: destination register index.
- `ALUrslt_M` in 32: ALU result / word address.
- `wdata_M` in 32: scalar store data.
- `regVrslt_M` in 32·LANES: vector ALU result / vector store data.
- `mem_addr` out ADDR_W: memory word address.
- `mem_data` out 32: memory write data.
- `mem_wren` out 1: memory write enable.
- `mem_q` in 32: memory read data, valid one cycle after address.
- `stall_M` out 1: hold upstream pipe registers.
- `regw_MW`, `regmem_MW` out 1 each: to `mwpipe`.
- `regScr_MW` out 4, `ALUrslt_MW` out 32, `regVrslt_MW` out 32·LANES: to `mwpipe`.

## Operation
- FSM states: IDLE, SLD (scalar load wait), VLD (vector load beats), VST (vector store beats). Beat counter `beat` is clog2(LANES) bits; lane buffer is 32·(LANES−1) bits.
- Base address is `ALUrslt_M[ADDR_W-1:0]`. Beat k addresses base+k modulo 2^ADDR_W (wraps silently).
- Lane k occupies bits [32k+31:32k].
- Priority when `valid_M`: `memwr_M` (store) over `regmem_M` (load). A store forces `regw_MW`=0.
- Non-memory op: pure pass-through, no stall. `ALUrslt_MW`=`ALUrslt_M`, `regVrslt_MW`=`regVrslt_M`.
- Scalar store: `mem_wren`=1 and `mem_data`=`wdata_M` in the same cycle, no stall.
- Scalar load: IDLE→SLD with address issued. In SLD: `ALUrslt_MW`=`mem_q`, then →IDLE.
- Vector store: IDLE→VST. Lane `beat` is written each cycle. Exit to IDLE after lane LANES−1.
- Vector load: IDLE→VLD. Address beat k is issued each cycle, and `mem_q` is captured into lane k−1. On the final cycle, `regVrslt_MW`={`mem_q`, buffer} and the FSM returns to IDLE.
- Whenever `stall_M`=1, outputs to `mwpipe` form a bubble: `regw_MW`=0, `regmem_MW`=0.
- Upstream holds all `_M` inputs stable while `stall_M`=1.
- `valid_M`=0: bubble passed, no memory access.

## Timing
- Acceptance cycle A = the cycle the op is first presented in IDLE.
- Non-mem op / scalar store: 0 stall cycles; outputs valid in cycle A.
- Scalar load: `stall_M`=1 in A; result valid in A+1 with `stall_M`=0.
- Vector store: writes in A..A+LANES−1; `stall_M`=1 in A..A+LANES−2; low on the last beat.
- Vector load: reads issued in A..A+LANES−1; `stall_M`=1 in A..A+LANES−1; result valid in A+LANES.
- The next op is accepted in the cycle after `stall_M` falls.
- Reset, including mid-operation: FSM→IDLE, `beat`=0, lane buffer=0, `stall_M`=0, `mem_wren`=0, `regw_MW`=0, `regmem_MW`=0. Data-path outputs follow their inputs. Lanes already written stay in memory.

## Configuration
- `MEM_STAGE_PERF_EN` defined: adds output `stall_cnt` (32 bits). It counts cycles with `stall_M`=1, saturates at 32'hFFFFFFFF, and resets to 0.
- Not defined: the port and counter are absent; behaviour is otherwise identical.

## Test plan
- ALU op: `regw_M`=1, `regScr_M`=4'b0011, `ALUrslt_M`=32'h0000FFFF, no stall → same values on `_MW` in the same cycle, `mem_wren`=0.
- Scalar store then load at address 5: store 32'hDEADBEEF, then load → `stall_M` high for 1 cycle, then `ALUrslt_MW`=32'hDEADBEEF with `regmem_MW`=1.
- Vector store at base 8 with 128'h44444444_33333333_22222222_11111111 → words 8..11 = 11111111..44444444, `stall_M` high 3 cycles. A following vector load from base 8 → `stall_M` high 4 cycles, then `regVrslt_MW` equals the stored vector.
- Wrap: vector load at base 1022 (ADDR_W=10) → addresses 1022, 1023, 0, 1 in order.
- Reset asserted in the second VLD beat → `stall_M`=0 and `mem_wren`=0 immediately. After release, an ALU op passes with no stall.
- With `MEM_STAGE_PERF_EN`: the vector load above increments `stall_cnt` by 4.
